// File: rtl/wb_trace_buffer.sv
// ============================================================================
// Module      : wb_trace_buffer
// Description : Writeback trace FIFO with stream/circular modes, PC trigger
//               with post-trigger capture, and same-PC halt-loop detection.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module wb_trace_buffer #(
    parameter int XLEN      = 32,
    parameter int PC_W      = 32,
    parameter int DEPTH     = 16,
    parameter int POST_TRIG = 4,
    parameter int HALT_N    = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clear,
    input  logic                     mode,
    input  logic                     wb_valid,
    input  logic [PC_W-1:0]          wb_pc,
    input  logic                     wb_we,
    input  logic [4:0]               wb_rd,
    input  logic [XLEN-1:0]          wb_data,
    input  logic                     trig_en,
    input  logic [PC_W-1:0]          trig_pc,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [PC_W-1:0]          out_pc,
    output logic                     out_we,
    output logic [4:0]               out_rd,
    output logic [XLEN-1:0]          out_data,
    output logic [$clog2(DEPTH):0]   level,
    output logic [31:0]              retire_cnt,
    output logic [15:0]              drop_cnt,
    output logic                     frozen,
    output logic                     halt
);

    localparam int AW     = $clog2(DEPTH);
    localparam int LW     = AW + 1;
    localparam int PCNT_W = (POST_TRIG > 0) ? $clog2(POST_TRIG + 1) : 1;
    localparam int HCNT_W = $clog2(HALT_N + 1);

    localparam logic [LW-1:0]     FULL_LVL = LW'(DEPTH);
    localparam logic [HCNT_W-1:0] HALT_MAX = HCNT_W'(HALT_N);

    localparam logic [1:0] ST_RUN    = 2'd0;
    localparam logic [1:0] ST_POST   = 2'd1;
    localparam logic [1:0] ST_FROZEN = 2'd2;

    logic [PC_W-1:0] pc_mem   [DEPTH];
    logic            we_mem   [DEPTH];
    logic [4:0]      rd_mem   [DEPTH];
    logic [XLEN-1:0] data_mem [DEPTH];

    logic [1:0]        state_q,    state_d;
    logic [AW-1:0]     wptr_q,     wptr_d;
    logic [AW-1:0]     rptr_q,     rptr_d;
    logic [LW-1:0]     level_q,    level_d;
    logic [31:0]       retire_q,   retire_d;
    logic [15:0]       drop_q,     drop_d;
    logic [PCNT_W-1:0] post_q,     post_d;
    logic [PC_W-1:0]   prev_pc_q,  prev_pc_d;
    logic              prev_vld_q, prev_vld_d;
    logic [HCNT_W-1:0] same_q,     same_d;
    logic              halt_q,     halt_d;

    logic capture, pop, full, wr_en, trig_hit;

    always_comb begin
        capture  = wb_valid && !clear && (state_q != ST_FROZEN);
        pop      = (level_q != '0) && out_ready && !clear;
        full     = (level_q == FULL_LVL);
        // A full buffer still accepts the entry if a slot frees this cycle or we overwrite.
        wr_en    = capture && (pop || !full || mode);
        trig_hit = trig_en && (wb_pc == trig_pc);

        state_d    = state_q;
        wptr_d     = wptr_q;
        rptr_d     = rptr_q;
        level_d    = level_q;
        retire_d   = retire_q;
        drop_d     = drop_q;
        post_d     = post_q;
        prev_pc_d  = prev_pc_q;
        prev_vld_d = prev_vld_q;
        same_d     = same_q;
        halt_d     = halt_q;

        if (clear) begin
            state_d    = ST_RUN;
            wptr_d     = '0;
            rptr_d     = '0;
            level_d    = '0;
            retire_d   = '0;
            drop_d     = '0;
            post_d     = '0;
            prev_vld_d = 1'b0;
            same_d     = '0;
            halt_d     = 1'b0;
        end else begin
            if (wr_en)
                wptr_d = wptr_q + AW'(1);
            if (pop || (capture && full && mode))
                rptr_d = rptr_q + AW'(1);
            if (capture && !pop && !full)
                level_d = level_q + LW'(1);
            else if (pop && !capture)
                level_d = level_q - LW'(1);
            if (capture && full && !pop && (drop_q != 16'hFFFF))
                drop_d = drop_q + 16'd1;

            if (wb_valid) begin
                retire_d   = retire_q + 32'd1;
                prev_pc_d  = wb_pc;
                prev_vld_d = 1'b1;
                if (prev_vld_q && (wb_pc == prev_pc_q)) begin
                    if (same_q != HALT_MAX)
                        same_d = same_q + HCNT_W'(1);
                end else begin
                    same_d = HCNT_W'(1);
                end
                if (same_d == HALT_MAX)
                    halt_d = 1'b1;
            end

            case (state_q)
                ST_RUN: begin
                    if (capture && trig_hit) begin
                        if (POST_TRIG == 0) begin
                            state_d = ST_FROZEN;
                        end else begin
                            state_d = ST_POST;
                            post_d  = PCNT_W'(POST_TRIG);
                        end
                    end
                end
                ST_POST: begin
                    if (capture) begin
                        post_d = post_q - PCNT_W'(1);
                        if (post_q == PCNT_W'(1))
                            state_d = ST_FROZEN;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_RUN;
            wptr_q     <= '0;
            rptr_q     <= '0;
            level_q    <= '0;
            retire_q   <= '0;
            drop_q     <= '0;
            post_q     <= '0;
            prev_pc_q  <= '0;
            prev_vld_q <= 1'b0;
            same_q     <= '0;
            halt_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            level_q    <= level_d;
            retire_q   <= retire_d;
            drop_q     <= drop_d;
            post_q     <= post_d;
            prev_pc_q  <= prev_pc_d;
            prev_vld_q <= prev_vld_d;
            same_q     <= same_d;
            halt_q     <= halt_d;
        end
    end

    // Storage is not reset; the pointers and level alone define what is valid.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            pc_mem[wptr_q]   <= wb_pc;
            we_mem[wptr_q]   <= wb_we;
            rd_mem[wptr_q]   <= wb_we ? wb_rd : 5'd0;
            data_mem[wptr_q] <= wb_data;
        end
    end

    assign out_valid  = (level_q != '0);
    assign out_pc     = pc_mem[rptr_q];
    assign out_we     = we_mem[rptr_q];
    assign out_rd     = rd_mem[rptr_q];
    assign out_data   = data_mem[rptr_q];
    assign level      = level_q;
    assign retire_cnt = retire_q;
    assign drop_cnt   = drop_q;
    assign frozen     = (state_q == ST_FROZEN);
    assign halt       = halt_q;

endmodule

`default_nettype wire

// File: tb/tb_wb_trace_buffer.sv
// ============================================================================
// Module      : tb_wb_trace_buffer
// Description : Scoreboard bench for wb_trace_buffer (default parameters).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_wb_trace_buffer;

    localparam int DEPTH     = 16;
    localparam int POST_TRIG = 4;
    localparam int HALT_N    = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        clear = 1'b0;
    logic        mode = 1'b0;
    logic        wb_valid = 1'b0;
    logic [31:0] wb_pc = '0;
    logic        wb_we = 1'b0;
    logic [4:0]  wb_rd = '0;
    logic [31:0] wb_data = '0;
    logic        trig_en = 1'b0;
    logic [31:0] trig_pc = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_pc;
    logic        out_we;
    logic [4:0]  out_rd;
    logic [31:0] out_data;
    logic [4:0]  level;
    logic [31:0] retire_cnt;
    logic [15:0] drop_cnt;
    logic        frozen;
    logic        halt;

    wb_trace_buffer #(
        .XLEN(32), .PC_W(32), .DEPTH(DEPTH), .POST_TRIG(POST_TRIG), .HALT_N(HALT_N)
    ) dut (
        .clk(clk), .rst_n(rst_n), .clear(clear), .mode(mode),
        .wb_valid(wb_valid), .wb_pc(wb_pc), .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
        .trig_en(trig_en), .trig_pc(trig_pc),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_we(out_we), .out_rd(out_rd), .out_data(out_data),
        .level(level), .retire_cnt(retire_cnt), .drop_cnt(drop_cnt),
        .frozen(frozen), .halt(halt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic        we;
        logic [4:0]  rd;
        logic [31:0] data;
    } ent_t;

    ent_t        exp_q[$];
    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] m_retire;
    logic [15:0] m_drop;
    int          m_state;   // 0 run, 1 post, 2 frozen
    int          m_post;
    logic [31:0] m_prev_pc;
    bit          m_prev_vld;
    int          m_same;
    bit          m_halt;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_retire = '0; m_drop = '0; m_state = 0; m_post = 0;
        m_prev_pc = '0; m_prev_vld = 0; m_same = 0; m_halt = 0;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic check_head(input string tag);
        check({tag, "_valid"}, 64'(out_valid), 64'(1));
        check({tag, "_pc"},    64'(out_pc),    64'(exp_q[0].pc));
        check({tag, "_we"},    64'(out_we),    64'(exp_q[0].we));
        check({tag, "_rd"},    64'(out_rd),    64'(exp_q[0].rd));
        check({tag, "_data"},  64'(out_data),  64'(exp_q[0].data));
    endtask

    task automatic check_status(input string tag);
        check({tag, "_level"},  64'(level),      64'(exp_q.size()));
        check({tag, "_ovalid"}, 64'(out_valid),  64'(exp_q.size() != 0));
        check({tag, "_retire"}, 64'(retire_cnt), 64'(m_retire));
        check({tag, "_drop"},   64'(drop_cnt),   64'(m_drop));
        check({tag, "_frozen"}, 64'(frozen),     64'(m_state == 2));
        check({tag, "_halt"},   64'(halt),       64'(m_halt));
    endtask

    task automatic retire(input logic [31:0] pc, input bit we, input logic [4:0] rd,
                          input logic [31:0] data, input bit rdy);
        ent_t e;
        wb_valid = 1'b1; wb_pc = pc; wb_we = we; wb_rd = rd; wb_data = data;
        out_ready = rdy;
        if (rdy && exp_q.size() > 0) begin
            check_head("pushpop");
            void'(exp_q.pop_front());
        end
        m_retire++;
        if (m_prev_vld && pc == m_prev_pc) begin
            if (m_same < HALT_N) m_same++;
        end else begin
            m_same = 1;
        end
        m_prev_pc = pc; m_prev_vld = 1;
        if (m_same == HALT_N) m_halt = 1;
        if (m_state != 2) begin
            e.pc = pc; e.we = we; e.rd = we ? rd : 5'd0; e.data = data;
            if (exp_q.size() < DEPTH) begin
                exp_q.push_back(e);
            end else begin
                if (m_drop != 16'hFFFF) m_drop++;
                if (mode) begin
                    void'(exp_q.pop_front());
                    exp_q.push_back(e);
                end
            end
            if (m_state == 0 && trig_en && pc == trig_pc) begin
                if (POST_TRIG == 0) m_state = 2;
                else begin m_state = 1; m_post = POST_TRIG; end
            end else if (m_state == 1) begin
                m_post--;
                if (m_post == 0) m_state = 2;
            end
        end
        cyc();
        wb_valid = 1'b0; out_ready = 1'b0;
    endtask

    task automatic pop_step(input bit rdy);
        out_ready = rdy;
        if (rdy && exp_q.size() > 0) begin
            check_head("pop");
            void'(exp_q.pop_front());
        end
        cyc();
        out_ready = 1'b0;
    endtask

    task automatic drain(input string tag);
        out_ready = 1'b1;
        while (exp_q.size() > 0) begin
            check_head(tag);
            void'(exp_q.pop_front());
            cyc();
        end
        out_ready = 1'b0;
        check({tag, "_empty"}, 64'(out_valid), 64'(0));
    endtask

    // Clear is driven together with a retire and a pop, both of which must be ignored.
    task automatic do_clear();
        clear = 1'b1; wb_valid = 1'b1; wb_pc = 32'hDEAD; out_ready = 1'b1;
        cyc();
        clear = 1'b0; wb_valid = 1'b0; out_ready = 1'b0;
        model_reset();
    endtask

    initial begin
        model_reset();
        #3;
        check("rst_level", 64'(level), 64'(0));
        check("rst_ovalid", 64'(out_valid), 64'(0));
        check_status("rst");
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Stream overflow
        mode = 1'b0;
        for (int i = 0; i < 20; i++) retire(32'(i * 4), i[0], 5'(i), $urandom, 1'b0);
        check("strm_level", 64'(level), 64'(16));
        check("strm_drop", 64'(drop_cnt), 64'(4));
        check_status("strm");
        check("strm_first_pc", 64'(out_pc), 64'h00);
        drain("strm_drain");

        // Circular overflow
        do_clear();
        check_status("clr1");
        mode = 1'b1;
        for (int i = 0; i < 20; i++) retire(32'(i * 4), ~i[0], 5'(i + 3), $urandom, 1'b0);
        check("circ_level", 64'(level), 64'(16));
        check("circ_drop", 64'(drop_cnt), 64'(4));
        check("circ_first_pc", 64'(out_pc), 64'h10);
        check_status("circ");
        drain("circ_drain");

        // Full with simultaneous push and pop
        do_clear();
        mode = 1'b0;
        for (int i = 0; i < 16; i++) retire(32'(32'h200 + i * 4), 1'b1, 5'(i), $urandom, 1'b0);
        retire(32'h300, 1'b1, 5'd9, 32'hCAFE_F00D, 1'b1);
        check("pp_level", 64'(level), 64'(16));
        check("pp_drop", 64'(drop_cnt), 64'(0));
        check("pp_last_pc", 64'(exp_q[DEPTH-1].pc), 64'h300);
        check_status("pp");
        drain("pp_drain");

        // Trigger and post-trigger capture
        do_clear();
        trig_en = 1'b1; trig_pc = 32'h20;
        for (int i = 0; i < 20; i++) retire(32'(i * 4), 1'b1, 5'(i), $urandom, 1'b0);
        check("trig_frozen", 64'(frozen), 64'(1));
        check("trig_level", 64'(level), 64'(13));
        check("trig_retire", 64'(retire_cnt), 64'(20));
        check_status("trig");
        drain("trig_drain");
        check("trig_frozen_drained", 64'(frozen), 64'(1));
        trig_en = 1'b0;

        // Halt loop
        do_clear();
        for (int i = 0; i < 7; i++) retire(32'h44, 1'b0, 5'd1, 32'(i), 1'b0);
        check("halt_7", 64'(halt), 64'(0));
        retire(32'h44, 1'b0, 5'd1, 32'h7, 1'b0);
        check("halt_8", 64'(halt), 64'(1));
        retire(32'h48, 1'b1, 5'd2, 32'h8, 1'b0);
        check("halt_sticky", 64'(halt), 64'(1));
        check_status("halt");
        do_clear();
        check("halt_clr", 64'(halt), 64'(0));
        check("halt_clr_level", 64'(level), 64'(0));
        check("halt_clr_retire", 64'(retire_cnt), 64'(0));

        // Asynchronous reset between edges
        for (int i = 0; i < 5; i++) retire(32'(32'h80 + i * 4), 1'b1, 5'(i), $urandom, 1'b0);
        check("ar_pre_level", 64'(level), 64'(5));
        #2 rst_n = 1'b0;
        #1;
        check("ar_level", 64'(level), 64'(0));
        check("ar_ovalid", 64'(out_valid), 64'(0));
        model_reset();
        check_status("ar");
        #1 rst_n = 1'b1;
        for (int i = 0; i < 3; i++) retire(32'(32'h400 + i * 4), 1'b1, 5'(i + 1), $urandom, 1'b0);
        check_status("ar_post");
        drain("ar_drain");

        // Random mixed traffic
        mode = 1'b1;
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 2) != 0)
                retire(32'($urandom_range(0, 7) * 4), 1'($urandom), 5'($urandom), $urandom,
                       1'($urandom_range(0, 3) == 0));
            else
                pop_step(1'($urandom));
            if (i == 30) mode = 1'b0;
        end
        check_status("rand");
        drain("rand_drain");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/wb_trace_buffer.md
WB_TRACE_BUFFER -- requirements
Module: wb_trace_buffer

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
- XLEN, 32, writeback data width.
- PC_W, 32, PC width.
- DEPTH, 16, trace entries; power of 2, >= 2.
- POST_TRIG, 4, entries captured after the trigger entry.
- HALT_N, 8, consecutive same-PC retires that flag a halt.
REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk, in, 1, single clock, rising edge.
- rst_n, in, 1, asynchronous active-low reset.
- clear, in, 1, synchronous flush and re-arm.
- mode, in, 1, 0 = stream (drop when full), 1 = circular (overwrite oldest).
- wb_valid, in, 1, instruction retires this cycle.
- wb_pc, in, PC_W, PC of the retiring instruction.
- wb_we, in, 1, register write enable.
- wb_rd, in, 5, destination register.
- wb_data, in, XLEN, writeback value.
- trig_en, in, 1, enable PC trigger.
- trig_pc, in, PC_W, trigger PC.
- out_valid, out, 1, entry available.
- out_ready, in, 1, consumer accepts entry.
- out_pc, out, PC_W, head entry field.
- out_we, out, 1, head entry field.
- out_rd, out, 5, head entry field.
- out_data, out, XLEN, head entry field.
- level, out, clog2(DEPTH)+1, entries held.
- retire_cnt, out, 32, retired instructions, wraps.
- drop_cnt, out, 16, dropped entries, saturates at 0xFFFF.
- frozen, out, 1, capture stopped by trigger.
- halt, out, 1, sticky halt-loop flag.

Function
REQ-003 An entry SHALL be {wb_pc, wb_we, wb_rd (forced 0 when wb_we=0), wb_data}.
REQ-004 Capture SHALL happen on a clk edge with wb_valid=1, state RUN or POST, and clear=0.
REQ-005 Output SHALL be show-ahead: out_* reflect the head entry combinationally; out_valid = (level != 0).
REQ-006 Pop SHALL occur when out_valid and out_ready are both 1; out_* are don't-care while out_valid=0.
REQ-007 Push and pop in the same cycle SHALL leave level unchanged, at any level including full.
REQ-008 When full, mode=0 and no pop: the new entry SHALL be discarded and drop_cnt SHALL increment (saturating).
REQ-009 When full, mode=1 and no pop: the new entry SHALL overwrite the oldest; read pointer advances; level stays DEPTH; drop_cnt increments.
REQ-010 Pointers SHALL wrap modulo DEPTH; level SHALL never exceed DEPTH or go below 0.
REQ-011 retire_cnt SHALL increment on every wb_valid=1 cycle in every state, including FROZEN.
REQ-012 The state machine SHALL have three states: RUN, POST and FROZEN.
- RUN -> POST when a captured entry has trig_en=1 and wb_pc==trig_pc; post counter loads POST_TRIG.
- With POST_TRIG=0, RUN -> FROZEN directly on the trigger entry.
- POST: each captured entry decrements the post counter; on the capture that reaches 0, go to FROZEN.
- FROZEN: no capture, draining still allowed, frozen=1.
- A trigger match while in POST SHALL be ignored.
REQ-013 The trigger entry itself SHALL be captured and counts toward level and drops.
REQ-014 Halt detect: a same-PC counter SHALL increment when wb_valid=1 and wb_pc equals the previous retired PC. It resets to 1 on a differing PC. halt sets when the counter reaches HALT_N and stays set until clear or reset.
REQ-015 The same-PC counter SHALL saturate at HALT_N.
REQ-016 clear=1 SHALL empty the buffer and zero retire_cnt, drop_cnt, halt and the same-PC state. State goes to RUN. Any same-cycle wb_valid or pop SHALL be ignored.

Reset
REQ-017 While rst_n=0, regardless of clk, all outputs SHALL be:
- level=0, out_valid=0, retire_cnt=0, drop_cnt=0, frozen=0, halt=0.
- State RUN; pointers 0; previous-PC valid flag cleared.
REQ-018 Reset asserted mid-operation SHALL discard all held entries immediately; storage contents need not be cleared.
REQ-019 After rst_n deasserts, the first capture SHALL occur on the first clk edge with wb_valid=1.

Verification
REQ-020 Stream overflow (DEPTH=16, mode=0, out_ready=0): 20 retires, PCs 0x00..0x4C step 4 -> level=16, drop_cnt=4; then drain -> out_pc 0x00..0x3C in order.
REQ-021 Circular overflow (mode=1): same stimulus -> level=16, drop_cnt=4; drain -> out_pc 0x10..0x4C.
REQ-022 Full plus simultaneous push/pop (mode=0, full, out_ready=1, wb_valid=1) -> level stays 16, drop_cnt unchanged, new entry appears last.
REQ-023 Trigger (trig_pc=0x20, POST_TRIG=4, PCs step 4 from 0x00, 20 retires) -> frozen after PC 0x30 is captured, level=13, retire_cnt=20.
REQ-024 Halt loop (HALT_N=8): wb_pc=0x44 on 7 retires -> halt=0; 8th retire -> halt=1; differing PC keeps halt=1; clear -> halt=0, level=0, retire_cnt=0.
REQ-025 Async reset mid-burst (rst_n low between edges with level=5) -> level=0 and out_valid=0 before the next clk edge.
